// File: rtl/fine_delay_interp_pkg.sv
// Shared widths and types for the fine-delay interpolation stage of one DBF receive channel.
package fine_delay_interp_pkg;

  localparam int INPUT_WD  = 14;
  localparam int FRAC_WD   = 8;
  localparam int ADDR_WD   = 12;
  localparam int LUT_DEPTH = 2 ** ADDR_WD;
  localparam int FD_OUT_WD = INPUT_WD + 2;
  localparam int DIFF_WD   = INPUT_WD + 1;
  localparam int ACC_WD    = INPUT_WD + FRAC_WD + 2;

  localparam logic [ADDR_WD-1:0] PTR_MAX  = ADDR_WD'(LUT_DEPTH - 1);
  localparam logic [ADDR_WD-1:0] PTR_NEAR = ADDR_WD'(LUT_DEPTH - 2);

  // Half an output LSB in accumulator units, for round-half-up to Q.2.
  localparam logic signed [ACC_WD-1:0] RND_HALF = ACC_WD'(2 ** (FRAC_WD - 3));

  typedef logic signed [INPUT_WD-1:0]  sample_t;
  typedef logic [FRAC_WD-1:0]          mu_t;
  typedef logic signed [FD_OUT_WD-1:0] fd_out_t;

endpackage

// File: rtl/fine_delay_interp_if.sv
// Channel-side bundle of the fine-delay stage: control, coefficient LUT load port and sample stream.
interface fine_delay_interp_if;
  import fine_delay_interp_pkg::*;

  logic                tx_en;
  logic                start;
  logic [ADDR_WD-1:0]  lut_addr;
  logic                lut_we;
  mu_t                 lut_wdata;
  sample_t             fine_din;
  logic                fine_din_valid;
  fd_out_t             fine_dout;
  logic                fine_dout_valid;
  logic                fd_ptr_sat;

  modport master (
    output tx_en, start, lut_addr, lut_we, lut_wdata, fine_din, fine_din_valid,
    input  fine_dout, fine_dout_valid, fd_ptr_sat
  );

  modport slave (
    input  tx_en, start, lut_addr, lut_we, lut_wdata, fine_din, fine_din_valid,
    output fine_dout, fine_dout_valid, fd_ptr_sat
  );

endinterface

// File: rtl/fine_delay_interp_coef_ram.sv
// Interpolation coefficient store: one write port, one synchronous read port, no reset.
module fd_coef_ram #(
  parameter int ADDR_WD = 12,
  parameter int COEF_W  = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_WD-1:0] waddr,
  input  logic [COEF_W-1:0]  wdata,
  input  logic [ADDR_WD-1:0] raddr,
  output logic [COEF_W-1:0]  rdata
);

  logic [COEF_W-1:0] mem [0:(1 << ADDR_WD) - 1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fine_delay_interp.sv
// Fractional-sample delay by linear interpolation between consecutive coarse-delayed samples,
// mu stepped from the coefficient LUT once per accepted sample.
module fine_delay_interp
  import fine_delay_interp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  fine_delay_interp_if.slave bus
);

  function automatic fd_out_t round_q2(input logic signed [ACC_WD-1:0] acc);
    return FD_OUT_WD'((acc + RND_HALF) >>> (FRAC_WD - 2));
  endfunction

  logic                      acc_in;
  logic [ADDR_WD-1:0]        rd_ptr;
  logic                      ptr_sat;
  sample_t                   x_prev;
  mu_t                       coef_p0;

  sample_t                   x_cur_p0;
  sample_t                   x_prev_p0;
  logic                      vld_p0;

  logic signed [DIFF_WD-1:0] diff_p1;
  sample_t                   x_prev_p1;
  mu_t                       mu_p1;
  logic                      vld_p1;

  logic signed [FRAC_WD:0]   mu_s_p1;
  logic signed [ACC_WD-1:0]  acc_p1;
  fd_out_t                   dout_p2;
  logic                      vld_p2;

  assign acc_in = bus.fine_din_valid & ~bus.tx_en & bus.start;

  fd_coef_ram #(
    .ADDR_WD (ADDR_WD),
    .COEF_W  (FRAC_WD)
  ) u_coef_ram (
    .clk   (clk),
    .we    (bus.lut_we & ~bus.start),
    .waddr (bus.lut_addr),
    .wdata (bus.lut_wdata),
    .raddr (rd_ptr),
    .rdata (coef_p0)
  );

  // Window control, valids and the output register; everything collapses to 0 outside a window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      ptr_sat <= 1'b0;
      x_prev  <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      dout_p2 <= '0;
    end else if (!bus.start) begin
      rd_ptr  <= '0;
      ptr_sat <= 1'b0;
      x_prev  <= '0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      dout_p2 <= '0;
    end else begin
      vld_p0 <= acc_in;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      if (acc_in) begin
        x_prev <= bus.fine_din;
        if (rd_ptr != PTR_MAX) rd_ptr <= rd_ptr + 1'b1;
        if (rd_ptr == PTR_NEAR || rd_ptr == PTR_MAX) ptr_sat <= 1'b1;
      end
      if (vld_p1) dout_p2 <= round_q2(acc_p1);
    end
  end

  // S1 -> S2: slope between the current and previous sample, mu arrives from the LUT read.
  always_ff @(posedge clk) begin
    x_cur_p0  <= bus.fine_din;
    x_prev_p0 <= x_prev;
    diff_p1   <= DIFF_WD'(x_cur_p0) - DIFF_WD'(x_prev_p0);
    x_prev_p1 <= x_prev_p0;
    mu_p1     <= coef_p0;
  end

  // S3: x_prev + mu*(x_cur - x_prev) with FRAC_WD fractional bits.
  assign mu_s_p1 = $signed({1'b0, mu_p1});
  assign acc_p1  = (ACC_WD'(x_prev_p1) <<< FRAC_WD) + (ACC_WD'(diff_p1) * ACC_WD'(mu_s_p1));

  assign bus.fine_dout       = dout_p2;
  assign bus.fine_dout_valid = vld_p2;
  assign bus.fd_ptr_sat      = ptr_sat;

endmodule

// File: tb/tb_fine_delay_interp.sv
// Scoreboard bench for fine_delay_interp: a reference interpolator predicts every output and its arrival cycle.
module tb_fine_delay_interp;

  typedef struct {
    longint val;
    longint cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     n_chk = 0;
  int     n_err = 0;
  int     cyc = 0;
  int     lut_m [0:4095];
  int     prev_m = 0;
  int     ptr_m = 0;
  exp_t   q [$];

  fine_delay_interp_if bus();

  fine_delay_interp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of sample stream; predict the output of every accepted sample.
  task automatic step(input logic v, input int x, input logic tx);
    exp_t   e;
    longint mu;
    @(negedge clk);
    bus.lut_we         = 1'b0;
    bus.fine_din_valid = v;
    bus.fine_din       = 14'(x);
    bus.tx_en          = tx;
    if (v && !tx && bus.start) begin
      mu    = longint'(lut_m[ptr_m]);
      e.val = ((256 - mu) * longint'(prev_m) + mu * longint'(x) + 32) >>> 6;
      e.cyc = longint'(cyc) + 3;
      q.push_back(e);
      prev_m = x;
      if (ptr_m < 4095) ptr_m++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 1'b0);
  endtask

  task automatic lut_wr(input int addr, input int data);
    @(negedge clk);
    bus.fine_din_valid = 1'b0;
    bus.lut_we         = 1'b1;
    bus.lut_addr       = 12'(addr);
    bus.lut_wdata      = 8'(data);
    if (!bus.start) lut_m[addr] = data;
  endtask

  task automatic set_start(input logic s);
    @(negedge clk);
    bus.lut_we         = 1'b0;
    bus.fine_din_valid = 1'b0;
    bus.start          = s;
    if (!s) begin
      q.delete();
      prev_m = 0;
      ptr_m  = 0;
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.fine_dout_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexp_vld", bus.fine_dout_valid, 0);
      end else begin
        e = q.pop_front();
        chk("dout", $signed(bus.fine_dout), e.val);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    bus.tx_en          = 1'b0;
    bus.start          = 1'b0;
    bus.lut_addr       = '0;
    bus.lut_we         = 1'b0;
    bus.lut_wdata      = '0;
    bus.fine_din       = '0;
    bus.fine_din_valid = 1'b0;
    for (int i = 0; i < 4096; i++) lut_m[i] = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", $signed(bus.fine_dout), 0);
    chk("rst_vld", bus.fine_dout_valid, 0);
    chk("rst_sat", bus.fd_ptr_sat, 0);
    chk("rst_ptr", dut.rd_ptr, 0);
    @(negedge clk);
    rst = 1'b0;

    // Half-sample delay
    for (int i = 0; i < 4096; i++) lut_wr(i, 128);
    set_start(1'b1);
    step(1'b1, 100, 1'b0);
    step(1'b1, 200, 1'b0);
    step(1'b1, 300, 1'b0);
    idle(4);
    chk("half_hold", $signed(bus.fine_dout), 1000);
    set_start(1'b0);
    idle(1);
    chk("stop_dout", $signed(bus.fine_dout), 0);

    // Rounding at the Q.2 boundary
    lut_wr(0, 1);
    set_start(1'b1);
    step(1'b1, 1, 1'b0);
    idle(4);
    chk("round_lo", $signed(bus.fine_dout), 0);
    set_start(1'b0);
    set_start(1'b1);
    step(1'b1, 32, 1'b0);
    idle(4);
    chk("round_hi", $signed(bus.fine_dout), 1);
    set_start(1'b0);

    // Extremes
    lut_wr(0, 0);
    lut_wr(1, 0);
    set_start(1'b1);
    step(1'b1, 8191, 1'b0);
    step(1'b1, -8192, 1'b0);
    idle(4);
    chk("ext_mu0", $signed(bus.fine_dout), 32764);
    set_start(1'b0);
    lut_wr(0, 255);
    lut_wr(1, 255);
    set_start(1'b1);
    step(1'b1, -8192, 1'b0);
    step(1'b1, 8191, 1'b0);
    idle(4);
    chk("ext_mu255", $signed(bus.fine_dout), 32508);
    set_start(1'b0);

    // Pointer saturation
    set_start(1'b1);
    for (int i = 0; i < 4101; i++) step(1'b1, (i * 37) % 16384 - 8192, 1'b0);
    idle(4);
    chk("sat_flag", bus.fd_ptr_sat, 1);
    chk("sat_ptr", dut.rd_ptr, 4095);
    set_start(1'b0);
    @(posedge clk);
    #1;
    chk("sat_clr", bus.fd_ptr_sat, 0);
    chk("sat_ptr0", dut.rd_ptr, 0);

    // Gating and flush
    for (int i = 0; i < 64; i++) lut_wr(i, int'($urandom_range(0, 255)));
    set_start(1'b1);
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 16383)) - 8192,
           1'($urandom_range(0, 3) == 0));
    idle(4);
    chk("gate_ptr", dut.rd_ptr, ptr_m);
    step(1'b1, 4000, 1'b0);
    step(1'b1, -3000, 1'b0);
    set_start(1'b0);
    @(posedge clk);
    #1;
    chk("flush_vld", bus.fine_dout_valid, 0);
    chk("flush_dout", $signed(bus.fine_dout), 0);

    // LUT write protection, then reset mid-window
    lut_wr(0, 64);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.lut_we    = 1'b1;
    bus.lut_addr  = '0;
    bus.lut_wdata = 8'd7;
    lut_wr(1, 9);
    step(1'b1, 64, 1'b0);
    idle(4);
    chk("lut_prot", $signed(bus.fine_dout), 64);
    step(1'b1, 1000, 1'b0);
    step(1'b1, -1000, 1'b0);
    idle(4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_dout", $signed(bus.fine_dout), 0);
    chk("arst_vld", bus.fine_dout_valid, 0);
    chk("arst_sat", bus.fd_ptr_sat, 0);
    chk("arst_ptr", dut.rd_ptr, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    set_start(1'b0);
    set_start(1'b1);
    step(1'b1, 500, 1'b0);
    step(1'b1, 600, 1'b0);
    idle(4);
    chk("restart_ptr", dut.rd_ptr, 2);
    set_start(1'b0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #2;
    chk("drain", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
